entropy_byte_packer: RTL and testbench

ENTROPY_BYTE_PACKER -- requirements
Module: entropy_byte_packer

---
 rtl/entropy_byte_packer.sv | 106 ++++++++++
 tb/tb_entropy_byte_packer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/entropy_byte_packer.sv
// entropy_byte_packer: samples an entropy bit, packs bytes MSB-first into a FIFO and strobes them to a UART.
// Define ENTROPY_VON_NEUMANN_EN to enable von Neumann pair debiasing of the samples.
module entropy_byte_packer #(
  parameter int SAMPLE_DIV = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          raw_bit,
  input  logic                          tx_free,
  input  logic                          clear_ovf,
  output logic                          transmit,
  output logic [7:0]                    tx_byte,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  localparam int CW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, STROBE, HOLD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d, tx_q, tx_d;
  logic [2:0] bc_q, bc_d;
  logic push_q, push_d, ovf_q, ovf_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [7:0] mem [FIFO_DEPTH];
  logic smp, acc, abit, full, pop, wr, drop;
  assign smp = cnt_q == CW'(SAMPLE_DIV - 1);
`ifdef ENTROPY_VON_NEUMANN_EN
  logic half_q, half_d, first_q, first_d;
  // first_q holds the opening sample of a pair; a differing second sample yields first_q
  always_comb begin
    half_d  = smp ? ~half_q : half_q;
    first_d = (smp && !half_q) ? raw_bit : first_q;
    acc     = smp && half_q && (first_q ^ raw_bit);
    abit    = first_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      half_q  <= half_d;
      first_q <= first_d;
    end
  end
`else
  assign acc  = smp;
  assign abit = raw_bit;
`endif
  // sr_q already holds the complete byte in the cycle push_q is high
  always_comb begin
    cnt_d  = smp ? '0 : cnt_q + CW'(1);
    sr_d   = acc ? {sr_q[6:0], abit} : sr_q;
    bc_d   = acc ? bc_q + 3'd1 : bc_q;
    push_d = acc && bc_q == 3'd7;
    full   = lvl_q == LW'(FIFO_DEPTH);
    pop    = state_q == IDLE && tx_free && lvl_q != '0;
    wr     = push_q && (!full || pop);
    drop   = push_q && full && !pop;
    wp_d   = wr ? wp_q + AW'(1) : wp_q;
    rp_d   = pop ? rp_q + AW'(1) : rp_q;
    lvl_d  = lvl_q + LW'(wr) - LW'(pop);
    tx_d   = pop ? mem[rp_q] : tx_q;
    ovf_d  = drop || (ovf_q && !clear_ovf);
  end
  always_comb begin
    state_d = state_q == STROBE ? HOLD : state_q == HOLD ? IDLE : pop ? STROBE : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      bc_q    <= '0;
      push_q  <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      lvl_q   <= '0;
      tx_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bc_q    <= bc_d;
      push_q  <= push_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      lvl_q   <= lvl_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wp_q] <= sr_q;
  end
  always_comb begin
    transmit   = state_q == STROBE;
    tx_byte    = tx_q;
    fifo_level = lvl_q;
    overflow   = ovf_q;
  end
endmodule

// File: tb/tb_entropy_byte_packer.sv
// tb_entropy_byte_packer: scoreboard bench; bytes are queued as their bits are driven and popped on each strobe.
module tb_entropy_byte_packer;
  localparam int SD = 4;
  logic clk = 1'b0, rst_n = 1'b0, raw_bit = 1'b0, tx_free = 1'b0, clear_ovf = 1'b0;
  logic transmit, overflow;
  logic [7:0] tx_byte;
  logic [2:0] fifo_level;
  int pass = 0, total = 0, cyc = 0;
  logic [7:0] q [$];
  int st [$];
  entropy_byte_packer #(.SAMPLE_DIV(SD), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .raw_bit(raw_bit), .tx_free(tx_free), .clear_ovf(clear_ovf),
    .transmit(transmit), .tx_byte(tx_byte), .fifo_level(fifo_level), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string tag, int got, int exp);
    total++;
    if (got == exp) pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  always @(negedge clk) begin
    if (rst_n && transmit) begin
      st.push_back(cyc);
      if (q.size() == 0) chk("spurious_tx", int'(transmit), 0);
      else chk("tx_byte", int'(tx_byte), int'(q.pop_front()));
    end
  end
  task automatic send_bit(logic b);
    raw_bit = b;
    repeat (SD) @(posedge clk);
    #1;
  endtask
  task automatic send_val(logic b);
`ifdef ENTROPY_VON_NEUMANN_EN
    send_bit(b);
    send_bit(~b);
`else
    send_bit(b);
`endif
  endtask
  task automatic send_byte(logic [7:0] b, bit keep);
    for (int i = 7; i >= 0; i--) send_val(b[i]);
    if (keep) q.push_back(b);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    raw_bit = 1'b0;
    q.delete();
    st.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic wait_drain(int n);
    repeat (n) @(posedge clk);
    #1;
    chk("drained", q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_transmit", int'(transmit), 0);
    chk("rst_tx_byte", int'(tx_byte), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_overflow", int'(overflow), 0);
    do_reset();
    raw_bit = 1'b1;
`ifdef ENTROPY_VON_NEUMANN_EN
    repeat (80) @(posedge clk);
    #1;
    chk("const1_no_byte", int'(fifo_level), 0);
`else
    repeat (32) @(posedge clk);
    #1;
    chk("level_c32", int'(fifo_level), 0);
    @(posedge clk);
    #1;
    chk("level_c33", int'(fifo_level), 1);
    q.push_back(8'hFF);
    tx_free = 1'b1;
    wait_drain(10);
    tx_free = 1'b0;
`endif
    do_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    tx_free = 1'b1;
    wait_drain(20);
    chk("strobe_count", st.size(), 2);
    if (st.size() == 2) chk("strobe_gap", st[1] - st[0], 3);
    tx_free = 1'b0;
    do_reset();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    fork
      begin
        repeat (2) @(posedge clk);
        #1;
        chk("level_full", int'(fifo_level), 4);
        chk("ovf_before_drop", int'(overflow), 0);
      end
    join_none
    send_byte(8'h55, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("level_after_drop", int'(fifo_level), 4);
    chk("ovf_set", int'(overflow), 1);
    tx_free = 1'b1;
    wait_drain(16);
    chk("level_drained", int'(fifo_level), 0);
    chk("ovf_sticky", int'(overflow), 1);
    clear_ovf = 1'b1;
    @(posedge clk);
    #1 clear_ovf = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);
    tx_free = 1'b0;
    do_reset();
    send_byte(8'hC3, 1'b1);
    send_byte(8'h96, 1'b1);
    send_byte(8'hE7, 1'b1);
    tx_free = 1'b1;
    for (int k = 0; k < 20 && !transmit; k++) begin
      @(posedge clk);
      #1;
    end
    chk("strobe_seen", int'(transmit), 1);
    chk("level_mid_strobe", int'(fifo_level), 2);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("async_tx_drop", int'(transmit), 0);
    chk("async_level", int'(fifo_level), 0);
    chk("async_tx_byte", int'(tx_byte), 0);
    st.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_byte(8'h5A, 1'b1);
    wait_drain(10);
    chk("post_rst_strobes", st.size(), 1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
